// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler
// Periodic conversion sequencer for the serial ADC interface. A free-running
// period counter raises a one-cycle request every SAMPLE_DIV cycles; the FSM
// turns each request into a single adc_start pulse, follows the ADC
// data_valid handshake through its busy period and presents the captured
// 10-bit result as a one-cycle sample_valid strobe. Requests that cannot be
// served set the sticky overrun flag; conversions that stall set the sticky
// timeout_err flag.
//
// Optional feature, macro ADC_AVG_EN:
//   defined   -> sample is the truncated mean of the last four captures; the
//                first three captures after reset or an enable rise are not
//                strobed.
//   undefined -> sample is the raw ADC word and every capture is strobed.
//
// ADC handshake: adc_data_valid is high while the ADC is idle. A conversion
// is launched by a one-cycle adc_start; the ADC drops adc_data_valid while
// converting and raises it again when adc_data holds the new result. The
// scheduler only launches while adc_data_valid is high, and only captures on
// the first high cycle after the low phase was observed.
//
// dbg_state exposes the FSM state encoding (IDLE=0, ARM=1, WAIT_LOW=2,
// WAIT_HIGH=3, CAPTURE=4).

module adc_sample_scheduler #(
  parameter int unsigned SAMPLE_DIV = 1250,
  parameter int unsigned TIMEOUT    = 2047
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clr_err,
  output logic       adc_start,
  input  logic [9:0] adc_data,
  input  logic       adc_data_valid,
  output logic [9:0] sample,
  output logic       sample_valid,
  output logic       overrun,
  output logic       timeout_err,
  output logic [2:0] dbg_state
);

  // Wait counter must be able to hold TIMEOUT.
  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [15:0]   DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_CAPTURE   = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic [15:0]   period_cnt;

  logic req;
  logic wait_expired;
  logic capture_fire;
  logic wait_abort;
  logic overrun_set;

  assign dbg_state = state;

  // Request fires in the last cycle of each sample period, only while enabled.
  assign req = enable && (period_cnt == DIV_LAST);

  // The wait currently being timed has used its full budget.
  assign wait_expired = (wait_cnt == TO_LAST);

  // ADC result is ready: valid came back high while waiting for completion.
  assign capture_fire = (state == S_WAIT_HIGH) && adc_data_valid;

  // A wait state gives up only when its expected edge has not appeared.
  assign wait_abort = wait_expired &&
                      (((state == S_WAIT_LOW)  &&  adc_data_valid) ||
                       ((state == S_WAIT_HIGH) && !adc_data_valid));

  // A request is dropped unless the FSM is idle and the ADC is idle too.
  assign overrun_set = req && !((state == S_IDLE) && adc_data_valid);

  // Sample period counter: 0..SAMPLE_DIV-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (!enable) begin
      period_cnt <= '0;
    end else if (period_cnt == DIV_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 16'd1;
    end
  end

  // Conversion sequencer: launch, watch the valid low/high phases, time out.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      adc_start <= 1'b0;
    end else begin
      adc_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (req && adc_data_valid) begin
            state     <= S_ARM;
            adc_start <= 1'b1;
          end
        end
        S_ARM: begin
          state    <= S_WAIT_LOW;
          wait_cnt <= '0;
        end
        S_WAIT_LOW: begin
          if (!adc_data_valid) begin
            state    <= S_WAIT_HIGH;
            wait_cnt <= '0;
          end else if (wait_expired) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (adc_data_valid) begin
            state    <= S_CAPTURE;
            wait_cnt <= '0;
          end else if (wait_expired) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_CAPTURE: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef ADC_AVG_EN
  // Last three captures, hist0 newest; fill counts captures since restart.
  logic [9:0]  hist0;
  logic [9:0]  hist1;
  logic [9:0]  hist2;
  logic [1:0]  fill;
  logic        enable_q;
  logic [11:0] avg_sum;

  // Four 10-bit values sum to at most 4092, so 12 bits never overflow.
  assign avg_sum = 12'(hist0) + 12'(hist1) + 12'(hist2) + 12'(adc_data);

  // Averaged output: strobe only once four captures are in the window.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      hist0        <= '0;
      hist1        <= '0;
      hist2        <= '0;
      fill         <= '0;
      enable_q     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      enable_q     <= enable;
      sample_valid <= 1'b0;
      if (enable && !enable_q) begin
        // Fresh sampling run: forget the previous window.
        hist0 <= '0;
        hist1 <= '0;
        hist2 <= '0;
        fill  <= '0;
      end else if (capture_fire) begin
        hist2 <= hist1;
        hist1 <= hist0;
        hist0 <= adc_data;
        if (fill == 2'd3) begin
          sample       <= avg_sum[11:2];
          sample_valid <= 1'b1;
        end else begin
          fill <= fill + 2'd1;
        end
      end
    end
  end
`else
  // Raw output: every capture is presented with a one-cycle strobe.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= capture_fire;
      if (capture_fire) begin
        sample <= adc_data;
      end
    end
  end
`endif

  // Sticky fault flags: a set event in the same cycle as clr_err wins.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (wait_abort) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: directed scenarios with a timeline model
// of the scheduler, an ADC behavioural model and a sample scoreboard.

module tb_adc_sample_scheduler;

  localparam int DIV = 1000;
  localparam int TO  = 2047;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  always #10 sysclk = ~sysclk;

  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clr_err = 1'b0;
  logic       adc_start;
  logic [9:0] adc_data = 10'd0;
  logic       adc_data_valid = 1'b1;
  logic [9:0] sample;
  logic       sample_valid;
  logic       overrun;
  logic       timeout_err;
  logic [2:0] dbg_state;

  adc_sample_scheduler #(.SAMPLE_DIV(DIV), .TIMEOUT(TO)) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .enable        (enable),
    .clr_err       (clr_err),
    .adc_start     (adc_start),
    .adc_data      (adc_data),
    .adc_data_valid(adc_data_valid),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .overrun       (overrun),
    .timeout_err   (timeout_err),
    .dbg_state     (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int base = 0;
  bit cmp_on = 1'b0;
  int strobe_cnt = 0;

  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ADC behavioural model ----------------
  int         adc_busy_len = 800;
  int         adc_busy_left = 0;
  bit         adc_stuck_idle = 1'b0;
  logic [9:0] adc_vals[$];

  initial forever begin
    @(negedge sysclk);
    if (adc_busy_left > 0) begin
      adc_busy_left--;
      if (adc_busy_left == 0) adc_data_valid = 1'b1;
    end else if (adc_start === 1'b1 && !adc_stuck_idle) begin
      adc_data_valid = 1'b0;
      adc_busy_left  = adc_busy_len;
      if (adc_vals.size() > 0) adc_data = adc_vals.pop_front();
      else adc_data = 10'h2A5;
    end
  end

  // ---------------- timeline model of the scheduler ----------------
  // A conversion is described by its accept cycle, whether the low phase
  // has been seen, its current deadline and whether it has delivered.
  int         m_pos = 0;
  bit         m_conv = 1'b0;
  bit         m_low_seen = 1'b0;
  bit         m_delivered = 1'b0;
  int         m_acc = 0;
  int         m_dead = 0;
  bit         m_en_prev = 1'b0;
  int         m_hist[$];
  bit         m_req, m_occ, m_ovr_set, m_to_set, m_cap;
  logic [9:0] m_cap_val;
  int         m_sum;
  bit         e_start = 1'b0, e_sv = 1'b0, e_ovr = 1'b0, e_to = 1'b0;
  logic [9:0] e_sample = 10'd0;

  initial forever begin
    @(posedge sysclk);
    cyc++;
    m_ovr_set = 1'b0;
    m_to_set  = 1'b0;
    m_cap     = 1'b0;
    if (rst) begin
      m_pos = 0; m_conv = 1'b0; m_en_prev = 1'b0; m_hist.delete();
      e_start = 1'b0; e_sv = 1'b0; e_ovr = 1'b0; e_to = 1'b0; e_sample = 10'd0;
    end else begin
      m_req   = enable && (m_pos == DIV - 1);
      m_occ   = m_conv;
      e_start = 1'b0;
      e_sv    = 1'b0;
      if (m_conv) begin
        if (cyc == m_acc + 1) begin
          m_low_seen = 1'b0;           // start pulse done, waiting begins now
          m_dead     = cyc + TO;
        end else if (m_delivered) begin
          m_conv = 1'b0;
        end else if (!m_low_seen) begin
          if (!adc_data_valid) begin
            m_low_seen = 1'b1;
            m_dead     = cyc + TO;
          end else if (cyc == m_dead) begin
            m_conv = 1'b0; m_to_set = 1'b1;
          end
        end else begin
          if (adc_data_valid) begin
            m_delivered = 1'b1; m_cap = 1'b1; m_cap_val = adc_data;
          end else if (cyc == m_dead) begin
            m_conv = 1'b0; m_to_set = 1'b1;
          end
        end
      end
      if (m_req) begin
        if (!m_occ && adc_data_valid) begin
          m_conv = 1'b1; m_acc = cyc; m_delivered = 1'b0; e_start = 1'b1;
        end else begin
          m_ovr_set = 1'b1;
        end
      end
`ifdef ADC_AVG_EN
      if (enable && !m_en_prev) begin
        m_hist.delete();
      end else if (m_cap) begin
        m_hist.push_back(int'(m_cap_val));
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_hist.size() == 4) begin
          m_sum = 0;
          foreach (m_hist[i]) m_sum += m_hist[i];
          e_sv = 1'b1;
          e_sample = 10'(m_sum / 4);
        end
      end
`else
      if (m_cap) begin
        e_sv = 1'b1;
        e_sample = m_cap_val;
      end
`endif
      m_en_prev = enable;
      if (m_ovr_set) e_ovr = 1'b1; else if (clr_err) e_ovr = 1'b0;
      if (m_to_set)  e_to  = 1'b1; else if (clr_err) e_to  = 1'b0;
      m_pos = enable ? ((m_pos + 1) % DIV) : 0;
    end
  end

  // ---------------- compare process and scoreboard ----------------
  initial forever begin
    @(negedge sysclk);
    if (cmp_on) begin
      check("model_outputs", {18'd0, adc_start, sample_valid, overrun, timeout_err, sample},
            {18'd0, e_start, e_sv, e_ovr, e_to, e_sample});
      if (sample_valid === 1'b1) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got strobe with sample %0h expected no strobe (cycle %0d)", sample, cyc);
        end else begin
          check("sb_sample", sample, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic start_enable();
    enable = 1'b1;
    base = cyc;
  endtask

  task automatic wait_rel(input int k);
    while (cyc < base + k) @(negedge sysclk);
  endtask

  // ---------------- directed scenarios ----------------
  int s0;

  initial begin
    @(posedge sysclk);
    @(negedge sysclk);
    cmp_on = 1'b1;
    idle(2);
    check("reset_outputs", {adc_start, sample_valid, overrun, timeout_err, sample}, 14'd0);
    check("reset_state", dbg_state, 3'd0);
    rst = 1'b0;
    idle(3);

    // Nominal: 800-cycle conversions, starts at cycles 1000 and 2000.
    adc_busy_len = 800;
    s0 = strobe_cnt;
`ifndef ADC_AVG_EN
    exp_q.push_back(10'h2A5);
    exp_q.push_back(10'h2A5);
`endif
    start_enable();
    wait_rel(999);  check("start_999", adc_start, 1'b0);
    wait_rel(1000); check("start_1000", adc_start, 1'b1);
    wait_rel(1001); check("start_1001", adc_start, 1'b0);
    wait_rel(2000); check("start_2000", adc_start, 1'b1);
    wait_rel(2900);
`ifdef ADC_AVG_EN
    check("nominal_strobes", strobe_cnt - s0, 0);
`else
    check("nominal_strobes", strobe_cnt - s0, 2);
    check("nominal_sample", sample, 10'h2A5);
`endif
    check("nominal_flags", {overrun, timeout_err}, 2'b00);
    enable = 1'b0;
    idle(5);

    // Reset while waiting for valid high; ADC stays busy through the next request.
    adc_busy_len = 2000;
    s0 = strobe_cnt;
    start_enable();
    wait_rel(1500);
    check("rst_mid_in_wait_high", dbg_state, 3'd3);
    rst = 1'b1;
    wait_rel(1501);
    rst = 1'b0;
    check("rst_mid_outputs", {adc_start, sample_valid, overrun, timeout_err, sample}, 14'd0);
    check("rst_mid_state", dbg_state, 3'd0);
    wait_rel(2500); check("rst_ovr_before", overrun, 1'b0);
    wait_rel(2502); check("rst_ovr_after", overrun, 1'b1);
    wait_rel(3100); check("rst_stale_ignored", strobe_cnt - s0, 0);
    enable = 1'b0;
    idle(5);

    // Busy ADC: second request overruns while clr_err pulses in the same cycle.
    do_reset();
    idle(3);
    adc_busy_len = 1500;
    adc_vals.push_back(10'h3FF);
`ifndef ADC_AVG_EN
    exp_q.push_back(10'h3FF);
`endif
    s0 = strobe_cnt;
    start_enable();
    wait_rel(1999);
    check("busy_ovr_before", overrun, 1'b0);
    clr_err = 1'b1;
    wait_rel(2000);
    clr_err = 1'b0;
    check("busy_ovr_set_wins", overrun, 1'b1);
    wait_rel(2700);
`ifdef ADC_AVG_EN
    check("busy_strobes", strobe_cnt - s0, 0);
`else
    check("busy_strobes", strobe_cnt - s0, 1);
`endif
    enable = 1'b0;
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    check("busy_ovr_cleared", overrun, 1'b0);
    idle(3);

    // Timeout: ADC never leaves idle; flag rises TO cycles after WAIT_LOW entry.
    do_reset();
    idle(3);
    adc_stuck_idle = 1'b1;
    s0 = strobe_cnt;
    start_enable();
    wait_rel(1005);
    enable = 1'b0;
    wait_rel(1001 + TO - 1); check("timeout_early", timeout_err, 1'b0);
    wait_rel(1001 + TO);     check("timeout_flag", timeout_err, 1'b1);
    check("timeout_no_strobe", strobe_cnt - s0, 0);
    check("timeout_no_ovr", overrun, 1'b0);
    wait_rel(3100);
    clr_err = 1'b1;
    wait_rel(3101);
    clr_err = 1'b0;
    wait_rel(3102);
    check("timeout_cleared", timeout_err, 1'b0);
    adc_stuck_idle = 1'b0;
    idle(5);

    // Data patterns: captures 100..500, raw or averaged.
    do_reset();
    idle(3);
    adc_busy_len = 800;
    adc_vals.delete();
    for (int i = 1; i <= 5; i++) adc_vals.push_back(10'(i * 100));
`ifdef ADC_AVG_EN
    exp_q.push_back(10'd250);
    exp_q.push_back(10'd350);
`else
    for (int i = 1; i <= 5; i++) exp_q.push_back(10'(i * 100));
`endif
    s0 = strobe_cnt;
    start_enable();
    wait_rel(5900);
`ifdef ADC_AVG_EN
    check("data_strobes", strobe_cnt - s0, 2);
    check("data_last_sample", sample, 10'd350);
`else
    check("data_strobes", strobe_cnt - s0, 5);
    check("data_last_sample", sample, 10'd500);
`endif
    check("data_flags", {overrun, timeout_err}, 2'b00);
    enable = 1'b0;
    idle(5);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_scheduler.md
# adc_sample_scheduler

Periodic conversion sequencer for the serial ADC interface block. It issues `start` pulses at a fixed sample rate derived from `sysclk`, tracks each conversion through the ADC chip-select/valid handshake, captures the 10-bit result, and presents it downstream as a one-cycle strobed sample to the pedal effect pipeline. It also flags two faults: requests that arrive while a conversion is still in flight, and conversions that never complete.

## Interface
- `SAMPLE_DIV`, default 1250: sysclk cycles per sample period (50 MHz / 1250 = 40 kHz); legal range 1000..65535.
- `TIMEOUT`, default 2047: maximum sysclk cycles spent in either WAIT state before abort.
- `sysclk`  in  1  50 MHz system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  sampling enable.
- `clr_err`  in  1  one-cycle pulse; clears the sticky error flags.
- `adc_start`  out  1  to ADC interface `start`.
- `adc_data`  in  10  from ADC interface `data_from_adc`.
- `adc_data_valid`  in  1  from ADC interface `data_valid`: high when idle, low while converting.
- `sample`  out  10  captured sample.
- `sample_valid`  out  1  one-cycle strobe; `sample` is valid in that cycle.
- `overrun`  out  1  sticky: a sample request was dropped.
- `timeout_err`  out  1  sticky: a conversion was aborted.

## Operation
- Reset values: all outputs 0, FSM in IDLE, period counter 0.
- Period counter:
  - Counts 0..SAMPLE_DIV-1 while `enable`=1, then wraps to 0.
  - Raises an internal `req` for one cycle when count==SAMPLE_DIV-1.
  - When `enable`=0, the counter is forced to 0 and held, and no `req` is raised.
- FSM states:
  - IDLE:
    - `req` with `adc_data_valid`=1 → ARM.
    - `req` with `adc_data_valid`=0 sets `overrun` and drops the request; FSM stays in IDLE.
  - ARM: `adc_start`=1 for exactly this one cycle → WAIT_LOW.
  - WAIT_LOW:
    - `adc_data_valid`=0 → WAIT_HIGH.
    - Timeout → IDLE.
  - WAIT_HIGH:
    - `adc_data_valid`=1 → CAPTURE.
    - Timeout → IDLE.
  - CAPTURE: register `adc_data` into `sample`, pulse `sample_valid` → IDLE.
- Timeout counter:
  - Cleared on every state change; increments in WAIT_LOW and WAIT_HIGH.
  - When it reaches TIMEOUT: set `timeout_err`, return to IDLE, emit no sample.
- A `req` arriving in any state other than IDLE sets `overrun` and is dropped.
- Deasserting `enable` mid-conversion does not abort it; the in-flight sample is still delivered.
- `sample` holds its last value between strobes.
- Sticky flags:
  - `clr_err` clears both flags.
  - If a set event and `clr_err` occur in the same cycle, the set wins.
- `rst` mid-conversion returns the FSM to IDLE immediately; the ADC interface is not reset.
  - If the ADC interface is still converting, the next `req` sees `adc_data_valid`=0 and sets `overrun` per the IDLE rule.

## Timing
- `adc_start` is registered: high in the single cycle the FSM occupies ARM.
- `req` at cycle N → ARM at N+1 → `adc_start` high during N+1.
- `adc_data_valid` sampled high in WAIT_HIGH at edge M → CAPTURE at M+1, with `sample` and `sample_valid` updated at edge M+1.
  - Latency from the valid rising edge to the strobe is 1 cycle.
- A nominal conversion takes about 17 µs (~850 cycles), which fits within the 1250-cycle default period.
- The state and timeout counter widths must hold TIMEOUT; the period counter is 16 bits.

## Configuration
- `ADC_AVG_EN` defined:
  - `sample` = (sum of the last 4 captured values) >> 2, truncated.
  - The accumulator is 12 bits wide.
  - The first 3 captures after reset (or after `enable` rises) do not strobe `sample_valid`.
  - Latency is unchanged (still 1 cycle after the valid edge).
- `ADC_AVG_EN` undefined: `sample` = raw `adc_data`, and every capture strobes.

## Test plan
- Nominal, using SAMPLE_DIV=1000 and an ADC model returning 0x2A5 with an 800-cycle busy period:
  - `enable` rises → `adc_start` pulses at cycle 1000 and again at 2000.
  - Each strobe carries `sample`=0x2A5, and `overrun`=`timeout_err`=0 throughout.
- Busy ADC: model held busy (`adc_data_valid`=0) for 1500 cycles → `overrun` set at the next `req`, and exactly one `sample_valid` is seen for the completed conversion.
- Timeout: model never drops `adc_data_valid` → `timeout_err`=1 exactly TIMEOUT cycles after WAIT_LOW entry, with no strobe. Then `clr_err` pulse → flag returns to 0.
- Reset mid-conversion: assert `rst` in WAIT_HIGH → the next cycle shows all outputs 0 and no strobe. A stale completion is ignored.
- With `ADC_AVG_EN`, feed captures 100, 200, 300, 400, 500:
  - First strobe: `sample`=250.
  - Second strobe: `sample`=350.
  - No strobes for the first 3 captures.
- Simultaneous `clr_err` and an overrun event in the same cycle → `overrun` reads 1 afterwards.
